// File: rtl/select_sequencer_pkg.sv
// Shared definitions for the select-code scan sequencer: mode encodings,
// FSM state constants and default widths.
package select_seq_pkg;

    localparam int SEL_WIDTH_DEF  = 4;
    localparam int HOLD_WIDTH_DEF = 8;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP       = 2'b00;
    localparam mode_t MODE_DOWN     = 2'b01;
    localparam mode_t MODE_PINGPONG = 2'b10;
    localparam mode_t MODE_SINGLE   = 2'b11;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/select_sequencer_if.sv
// Command/status bundle between a scan controller and the select sequencer.
interface select_sequencer_if #(
    parameter int SEL_WIDTH  = 4,
    parameter int HOLD_WIDTH = 8
);
    logic                  start;
    logic                  stop;
    logic [1:0]            mode;
    logic [SEL_WIDTH-1:0]  first;
    logic [SEL_WIDTH-1:0]  last;
    logic [HOLD_WIDTH-1:0] hold;
    logic [SEL_WIDTH-1:0]  select;
    logic                  busy;
    logic                  step;
    logic                  done;

    modport master (
        output start, stop, mode, first, last, hold,
        input  select, busy, step, done
    );

    modport slave (
        input  start, stop, mode, first, last, hold,
        output select, busy, step, done
    );
endinterface

// File: rtl/select_sequencer_hold_timer.sv
// Loadable down-counter; expire is high whenever the count sits at zero.
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/select_sequencer.sv
// Scan sequencer: steps the decoder select code through a latched range in
// one of four modes, holding each value for a programmable number of cycles.
module select_sequencer
    import select_seq_pkg::*;
#(
    parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
    parameter int HOLD_WIDTH = HOLD_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    select_sequencer_if.slave bus
);

    localparam logic [SEL_WIDTH-1:0]  SEL_ONE  = {{(SEL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q,  state_d;
    mode_t                 mode_q,   mode_d;
    logic [SEL_WIDTH-1:0]  first_q,  first_d;
    logic [SEL_WIDTH-1:0]  last_q,   last_d;
    logic [HOLD_WIDTH-1:0] reload_q, reload_d;
    logic [SEL_WIDTH-1:0]  select_q, select_d;
    logic                  dir_q,    dir_d;
    logic                  step_q,   step_d;
    logic                  done_q,   done_d;

    logic                  timer_load;
    logic [HOLD_WIDTH-1:0] timer_value;
    logic                  timer_expire;
    logic [HOLD_WIDTH-1:0] start_reload;

    logic [SEL_WIDTH-1:0]  next_code;
    logic                  next_dir;
    logic                  next_step;
    logic                  next_done;

    // Hold of zero behaves like one, so the timer reload is max(hold,1)-1.
    assign start_reload = (bus.hold == '0) ? '0 : (bus.hold - HOLD_ONE);

    hold_timer #(
        .WIDTH (HOLD_WIDTH)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // Successor of the current code once its hold has run out; all index
    // arithmetic wraps naturally at the select width.
    always_comb begin
        next_code = select_q;
        next_dir  = dir_q;
        next_step = 1'b1;
        next_done = 1'b0;
        case (mode_q)
            MODE_UP: begin
                next_code = (select_q == last_q) ? first_q : (select_q + SEL_ONE);
            end
            MODE_DOWN: begin
                next_code = (select_q == first_q) ? last_q : (select_q - SEL_ONE);
            end
            MODE_PINGPONG: begin
                if (first_q == last_q) begin
                    next_step = 1'b0;
                end else if (!dir_q) begin
                    if (select_q == last_q) begin
                        next_code = select_q - SEL_ONE;
                        next_dir  = 1'b1;
                    end else begin
                        next_code = select_q + SEL_ONE;
                    end
                end else begin
                    if (select_q == first_q) begin
                        next_code = select_q + SEL_ONE;
                        next_dir  = 1'b0;
                    end else begin
                        next_code = select_q - SEL_ONE;
                    end
                end
            end
            default: begin
                if (select_q == last_q) begin
                    next_step = 1'b0;
                    next_done = 1'b1;
                end else begin
                    next_code = select_q + SEL_ONE;
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        first_d     = first_q;
        last_d      = last_q;
        reload_d    = reload_q;
        select_d    = select_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_value = reload_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d     = ST_RUN;
                    mode_d      = bus.mode;
                    first_d     = bus.first;
                    last_d      = bus.last;
                    reload_d    = start_reload;
                    select_d    = (bus.mode == MODE_DOWN) ? bus.last : bus.first;
                    dir_d       = 1'b0;
                    step_d      = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = start_reload;
                end
            end
            default: begin
                // Stop outranks a coincident expiry: no advance, no pulses.
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    timer_load = 1'b1;
                    select_d   = next_code;
                    dir_d      = next_dir;
                    step_d     = next_step;
                    done_d     = next_done;
                    if (next_done) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_UP;
            first_q  <= '0;
            last_q   <= '0;
            reload_q <= '0;
            select_q <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            last_q   <= last_d;
            reload_q <= reload_d;
            select_q <= select_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    assign bus.select = select_q;
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.step   = step_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_select_sequencer.sv
// Directed cycle-by-cycle vector table for select_sequencer, plus two
// hand-written multi-cycle sequences (retrigger marker, wrapped single-shot).
module tb_select_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    select_sequencer_if #(.SEL_WIDTH(4), .HOLD_WIDTH(8)) bus ();

    select_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [1:0] mode;
        logic [3:0] first;
        logic [3:0] last;
        logic [7:0] hold;
        logic [3:0] e_sel;
        logic       e_busy;
        logic       e_step;
        logic       e_done;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int r, int s, int p, int m, int f, int l, int h,
                                int es, int eb, int est, int ed, string n);
        vec_t v;
        v.rst    = 1'(r);
        v.start  = 1'(s);
        v.stop   = 1'(p);
        v.mode   = 2'(m);
        v.first  = 4'(f);
        v.last   = 4'(l);
        v.hold   = 8'(h);
        v.e_sel  = 4'(es);
        v.e_busy = 1'(eb);
        v.e_step = 1'(est);
        v.e_done = 1'(ed);
        v.name   = n;
        vecs.push_back(v);
    endfunction

    // Running cycle with junk configuration on the inputs (must be ignored).
    function automatic void nx(int es, int est, string n);
        add(0, 0, 0, 1, 9, 12, 7, es, 1, est, 0, n);
    endfunction

    function automatic void stp(int es, string n);
        add(0, 0, 1, 2, 9, 12, 7, es, 0, 0, 0, n);
    endfunction

    function automatic void idl(int es, string n);
        add(0, 0, 0, 1, 9, 12, 7, es, 0, 0, 0, n);
    endfunction

    task automatic drive(input int r, input int s, input int p, input int m,
                         input int f, input int l, input int h);
        rst       = 1'(r);
        bus.start = 1'(s);
        bus.stop  = 1'(p);
        bus.mode  = 2'(m);
        bus.first = 4'(f);
        bus.last  = 4'(l);
        bus.hold  = 8'(h);
    endtask

    task automatic check(input string n, input logic [3:0] es, input logic eb,
                         input logic est, input logic ed);
        checks++;
        if (bus.select !== es || bus.busy !== eb || bus.step !== est || bus.done !== ed) begin
            errors++;
            $display("FAIL %s: got sel=%0d busy=%0b step=%0b done=%0b, want sel=%0d busy=%0b step=%0b done=%0b",
                     n, bus.select, bus.busy, bus.step, bus.done, es, eb, est, ed);
        end else begin
            $display("ok   %s: sel=%0d busy=%0b step=%0b done=%0b",
                     n, bus.select, bus.busy, bus.step, bus.done);
        end
    endtask

    initial begin
        int        nsteps;
        int        cyc;
        bit        sel_ok;
        bit        got_done;
        logic [3:0] seen[$];

        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset, with start asserted alongside to show reset priority.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        add(1, 1, 0, 0, 2, 5, 3, 0, 0, 0, 0, "reset_with_start");
        idl(0, "idle_after_reset");

        // Up-wrap 2..5, hold 3.
        add(0, 1, 0, 0, 2, 5, 3, 2, 1, 1, 0, "up_start");
        nx(2, 0, "up_2b"); nx(2, 0, "up_2c");
        nx(3, 1, "up_3a"); nx(3, 0, "up_3b"); nx(3, 0, "up_3c");
        nx(4, 1, "up_4a"); nx(4, 0, "up_4b"); nx(4, 0, "up_4c");
        nx(5, 1, "up_5a"); nx(5, 0, "up_5b"); nx(5, 0, "up_5c");
        nx(2, 1, "up_wrap_2a"); nx(2, 0, "up_wrap_2b");
        stp(2, "up_stop");
        idl(2, "up_idle");

        // Down-wrap over wrapped range 14..1, hold 1.
        add(0, 1, 0, 1, 14, 1, 1, 1, 1, 1, 0, "dn_start");
        nx(0, 1, "dn_0"); nx(15, 1, "dn_15"); nx(14, 1, "dn_14");
        nx(1, 1, "dn_1"); nx(0, 1, "dn_0b");
        stp(0, "dn_stop_at_expiry");
        idl(0, "dn_idle");

        add(0, 1, 1, 0, 2, 5, 3, 0, 0, 0, 0, "start_and_stop_idle");
        idl(0, "still_idle");

        // Ping-pong 0..3, hold 2.
        add(0, 1, 0, 2, 0, 3, 2, 0, 1, 1, 0, "pp_start");
        nx(0, 0, "pp_0b");
        nx(1, 1, "pp_1a"); nx(1, 0, "pp_1b");
        nx(2, 1, "pp_2a"); nx(2, 0, "pp_2b");
        nx(3, 1, "pp_3a"); nx(3, 0, "pp_3b");
        nx(2, 1, "pp_d2a"); nx(2, 0, "pp_d2b");
        nx(1, 1, "pp_d1a"); nx(1, 0, "pp_d1b");
        nx(0, 1, "pp_d0a"); nx(0, 0, "pp_d0b");
        nx(1, 1, "pp_u1a"); nx(1, 0, "pp_u1b");
        stp(1, "pp_stop_at_expiry");

        // Ping-pong with first==last: one step only.
        add(0, 1, 0, 2, 7, 7, 1, 7, 1, 1, 0, "ppc_start");
        nx(7, 0, "ppc_a"); nx(7, 0, "ppc_b"); nx(7, 0, "ppc_c"); nx(7, 0, "ppc_d");
        stp(7, "ppc_stop");

        // Single-shot 4..6, hold 0, restart in the done cycle.
        add(0, 1, 0, 3, 4, 6, 0, 4, 1, 1, 0, "ss_start");
        nx(5, 1, "ss_5"); nx(6, 1, "ss_6");
        add(0, 0, 0, 1, 9, 12, 7, 6, 0, 0, 1, "ss_done");
        add(0, 1, 0, 3, 4, 6, 0, 4, 1, 1, 0, "ss_restart");
        nx(5, 1, "ss2_5"); nx(6, 1, "ss2_6");
        add(0, 0, 0, 1, 9, 12, 7, 6, 0, 0, 1, "ss2_done");
        idl(6, "ss_hold_last");

        // Reset mid-scan.
        add(0, 1, 0, 0, 8, 10, 2, 8, 1, 1, 0, "rm_start");
        nx(8, 0, "rm_8b"); nx(9, 1, "rm_9a");
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_scan");
        idl(0, "rm_idle");

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].mode,
                  vecs[i].first, vecs[i].last, vecs[i].hold);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_step, vecs[i].e_done);
        end

        // Up-wrap with first==last, hold 5: step every 5 cycles as a marker.
        @(negedge clk);
        drive(0, 1, 0, 0, 3, 3, 5);
        nsteps = 0;
        sel_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.step === 1'b1) nsteps++;
            if (bus.select !== 4'd3 || bus.busy !== 1'b1) sel_ok = 1'b0;
            @(negedge clk);
            drive(0, 0, 0, 1, 9, 12, 7);
        end
        checks++;
        if (nsteps != 4 || !sel_ok) begin
            errors++;
            $display("FAIL retrigger: got steps=%0d sel_const=%0b, want steps=4 sel_const=1", nsteps, sel_ok);
        end else begin
            $display("ok   retrigger: steps=%0d", nsteps);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("retrigger_stop", 4'd3, 1'b0, 1'b0, 1'b0);

        // Wrapped single-shot 15..1, hold 2: done on the 7th edge.
        @(negedge clk);
        drive(0, 1, 0, 3, 15, 1, 2);
        cyc = 0;
        got_done = 1'b0;
        seen.delete();
        while (cyc < 50 && !got_done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.step === 1'b1) seen.push_back(bus.select);
            if (bus.done === 1'b1) got_done = 1'b1;
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        checks++;
        if (!got_done || cyc != 7) begin
            errors++;
            $display("FAIL ss_wrap_latency: got done=%0b at cycle %0d, want done=1 at cycle 7", got_done, cyc);
        end else begin
            $display("ok   ss_wrap_latency: cycle %0d", cyc);
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== 4'd15 || seen[1] !== 4'd0 || seen[2] !== 4'd1) begin
            errors++;
            $display("FAIL ss_wrap_codes: got %0d step codes %p, want 15 0 1", seen.size(), seen);
        end else begin
            $display("ok   ss_wrap_codes: 15 0 1");
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.select !== 4'd1) begin
            errors++;
            $display("FAIL ss_wrap_end: got busy=%0b sel=%0d, want busy=0 sel=1", bus.busy, bus.select);
        end else begin
            $display("ok   ss_wrap_end: busy=0 sel=1");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/select_sequencer.md
# select_sequencer

Programmable scan sequencer that produces the 4-bit `select` code consumed by the 4-to-16 decoder, directly upstream of it. On a start command it steps `select` through a latched range [first..last] in one of four scan modes. Each value is held for a programmable number of clock cycles. Status outputs report activity, each value change, and single-shot completion.

## Interface
- SEL_WIDTH, 4: width of `select`, `first`, `last`; must match decoder select width
- HOLD_WIDTH, 8: width of `hold`

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- stop  in  1  abort a scan; sampled only in RUN
- mode  in  2  scan mode: 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single-shot up
- first  in  SEL_WIDTH  range start code
- last  in  SEL_WIDTH  range end code
- hold  in  HOLD_WIDTH  cycles per value; 0 is treated as 1
- select  out  SEL_WIDTH  current code, registered; drives decoder
- busy  out  1  high while in RUN
- step  out  1  one-cycle pulse in the first cycle of each new `select` value
- done  out  1  one-cycle pulse when a single-shot scan completes

## Operation
- Reset: state=IDLE; select=0, busy=0, step=0, done=0; hold counter=0; ping-pong direction=up.
- States:
  - IDLE: `start`=1 and `stop`=0 latches mode/first/last/hold and moves to RUN. `start` and `stop` both high means stay in IDLE.
  - RUN: advance `select` when the hold counter expires. `stop` returns to IDLE.
- Configuration is latched at start. Input changes during RUN are ignored.
- Index arithmetic is modulo 2^SEL_WIDTH. A range with first > last wraps through 15→0, e.g. first=14, last=1 scans 14,15,0,1.
- Scan modes:
  - Up-wrap: first, first+1 … last, then first, repeating.
  - Down-wrap: starts at last, then last-1 … first, then last, repeating.
  - Ping-pong: first→last ascending, then last-1→first descending, repeating. End values are not repeated. With first==last, `select` stays constant and `step` pulses only once.
  - Single-shot: first→last ascending once. At expiry of `last`'s hold, go to IDLE and pulse `done`. `select` keeps `last`.
- first==last in up-wrap or down-wrap: `select` is constant and `step` pulses every hold period. This acts as a re-trigger marker.
- `stop` in the same cycle as a hold expiry: stop wins. No advance, no `step`, no `done`.
- `start` during RUN is ignored.
- On leaving RUN (by stop or single-shot end), `select` keeps its last value.

## Timing
- Start at edge N:
  - Edge N+1: select = start code (first, or last for down-wrap); busy=1; step=1.
- Each value is held for H = max(hold,1) cycles. The next value and `step` appear H cycles after the previous `step`.
- hold=1: `select` changes every cycle and `step` stays high continuously.
- Single-shot:
  - `done` is high in the cycle after the last hold expires.
  - busy=0 in that same cycle.
  - A new `start` is accepted in that cycle.
- Stop sampled at edge M: busy=0 from edge M+1.
- Reset mid-scan: all outputs return to reset values at the next edge. Reset takes priority over every other input.
- Fixed latency: one cycle from input sample to registered output.

## Structure
- Shared package `select_seq_pkg` holds:
  - mode encodings: MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_SINGLE
  - state enum: ST_IDLE, ST_RUN
  - default widths
- One sub-module, `hold_timer`. It is a loadable down-counter:
  - inputs: load, load value max(hold,1)-1
  - output: `expire` when the count is 0
- The top level contains the FSM, next-code logic and ping-pong direction flag.

## Test plan
- Reset values and up-wrap: reset, then mode=00, first=2, last=5, hold=3, start. Expect select 2,3,4,5,2 …, each held 3 cycles; step every 3rd cycle; busy=1.
- Wrapped range, down-wrap: mode=01, first=14, last=1, hold=1. Expect select 1,0,15,14,1,0 … changing every cycle; step constantly high.
- Ping-pong: first=0, last=3, hold=2. Expect 0,1,2,3,2,1,0,1 …, 2 cycles each. With first=last=7, expect a constant 7 and exactly one step pulse.
- Single-shot and back-to-back start: mode=11, first=4, last=6, hold=0 (treated as 1). Expect 4,5,6, then done=1 and busy=0 in the same cycle, select held at 6. A start in the done cycle restarts at 4 the next cycle.
- Stop and reset corner cases:
  - stop coincident with hold expiry: no advance, busy=0 next cycle, select unchanged.
  - start+stop together in IDLE: no scan.
  - rst asserted mid-scan: select=0, busy=0, step=0, done=0 next cycle.
